// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle between a producer/consumer pair and a sync_fifo_flags instance.
// The master side drives the requests, and the slave side (the FIFO) returns data and status.
interface sync_fifo_flags_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// an optional first-word-fall-through read port and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 3,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_V  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_V  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_V = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc_s, rd_acc_s;

    // Acceptance, pointer/count update and next-state flag decode.
    always_comb begin
        wr_acc_s    = bus.winc && !wfull_q;
        rd_acc_s    = bus.rinc && !rempty_q;
        wptr_d      = wr_acc_s ? wptr_q + ASIZE'(1) : wptr_q;
        rptr_d      = rd_acc_s ? rptr_q + ASIZE'(1) : rptr_q;
        rdata_d     = rd_acc_s ? mem_q[rptr_q] : rdata_q;
        count_d     = count_q;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + (ASIZE+1)'(1);
            2'b01:   count_d = count_q - (ASIZE+1)'(1);
            default: count_d = count_q;
        endcase
        // Flags are registered from the next count so they match a decode of count_q.
        wfull_d     = (count_d == DEPTH_V);
        rempty_d    = (count_d == '0);
        afull_d     = (count_d >= AFULL_V);
        aempty_d    = (count_d <= AEMPTY_V);
        overflow_d  = overflow_q  || (bus.winc && wfull_q);
        underflow_d = underflow_q || (bus.rinc && rempty_q);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_q[wptr_q] <= bus.wdata;
        end
    end

    assign bus.rdata         = (FWFT != 0) ? mem_q[rptr_q] : rdata_q;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = afull_q;
    assign bus.ralmost_empty = aempty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a vector table for basic traffic on a standard-read
// instance, then hand-written fill/drain/wrap sequences and a FWFT instance.
module tb_sync_fifo_flags;
    logic clk;
    logic rst0;
    logic rst1;
    int   errors;
    int   checks;

    sync_fifo_flags_if #(.DSIZE(8), .ASIZE(3)) bus0 ();
    sync_fifo_flags_if #(.DSIZE(8), .ASIZE(3)) bus1 ();

    sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       winc;
        logic       rinc;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [3:0] count;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst0       = r;
        bus0.winc  = w;
        bus0.rinc  = rd;
        bus0.wdata = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst1       = r;
        bus1.winc  = w;
        bus1.rinc  = rd;
        bus1.wdata = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive0(1'b1, 1'b0, 1'b0, 8'h00);
        drive1(1'b1, 1'b0, 1'b0, 8'h00);

        //            rst   winc  rinc  wdata  | rdata  cnt   full  empty afull aempt ovf   unf
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h44, 8'h33, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h44, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 11; v++) begin
            drive0(vecs[v].rst, vecs[v].winc, vecs[v].rinc, vecs[v].wdata);
            tick();
            chk($sformatf("vec%0d rdata", v),  32'(bus0.rdata),         32'(vecs[v].rdata));
            chk($sformatf("vec%0d count", v),  32'(bus0.count),         32'(vecs[v].count));
            chk($sformatf("vec%0d wfull", v),  32'(bus0.wfull),         32'(vecs[v].full));
            chk($sformatf("vec%0d rempty", v), 32'(bus0.rempty),        32'(vecs[v].empty));
            chk($sformatf("vec%0d afull", v),  32'(bus0.walmost_full),  32'(vecs[v].afull));
            chk($sformatf("vec%0d aempty", v), 32'(bus0.ralmost_empty), 32'(vecs[v].aempty));
            chk($sformatf("vec%0d ovf", v),    32'(bus0.overflow),      32'(vecs[v].ovf));
            chk($sformatf("vec%0d unf", v),    32'(bus0.underflow),     32'(vecs[v].unf));
        end

        // Fill past full: 11 writes, last 3 discarded.
        for (int i = 0; i < 11; i++) begin
            drive0(1'b0, 1'b1, 1'b0, 8'h50 + 8'(i));
            tick();
            chk($sformatf("fill%0d count", i), 32'(bus0.count),        (i < 8) ? 32'(i + 1) : 32'd8);
            chk($sformatf("fill%0d wfull", i), 32'(bus0.wfull),        32'(i >= 7));
            chk($sformatf("fill%0d afull", i), 32'(bus0.walmost_full), 32'(i >= 5));
            chk($sformatf("fill%0d ovf", i),   32'(bus0.overflow),     32'(i >= 8));
        end

        // Drain past empty: 8 words in order, then rdata holds the last one.
        for (int i = 0; i < 11; i++) begin
            drive0(1'b0, 1'b0, 1'b1, 8'h00);
            tick();
            chk($sformatf("drain%0d rdata", i), 32'(bus0.rdata),     (i < 8) ? 32'(8'h50 + 8'(i)) : 32'h57);
            chk($sformatf("drain%0d count", i), 32'(bus0.count),     (i < 8) ? 32'(7 - i) : 32'd0);
            chk($sformatf("drain%0d unf", i),   32'(bus0.underflow), 32'(i >= 8));
        end
        chk("drain rempty", 32'(bus0.rempty), 32'd1);

        drive0(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("rst2 ovf", 32'(bus0.overflow),  32'd0);
        chk("rst2 unf", 32'(bus0.underflow), 32'd0);

        // Four words in, then five cycles of simultaneous read and write.
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
            tick();
        end
        chk("sim pre count", 32'(bus0.count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            drive0(1'b0, 1'b1, 1'b1, 8'h64 + 8'(i));
            tick();
            chk($sformatf("sim%0d rdata", i), 32'(bus0.rdata), 32'(8'h60 + 8'(i)));
            chk($sformatf("sim%0d count", i), 32'(bus0.count), 32'd4);
        end
        // Top up to full across the pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, 1'b1, 1'b0, 8'h69 + 8'(i));
            tick();
        end
        chk("wrap full", 32'(bus0.wfull), 32'd1);
        // Read and write together while full: read accepted, write dropped.
        drive0(1'b0, 1'b1, 1'b1, 8'hEE);
        tick();
        chk("fullboth rdata", 32'(bus0.rdata),    32'h65);
        chk("fullboth count", 32'(bus0.count),    32'd7);
        chk("fullboth ovf",   32'(bus0.overflow), 32'd1);
        for (int i = 0; i < 7; i++) begin
            drive0(1'b0, 1'b0, 1'b1, 8'h00);
            tick();
            chk($sformatf("wrapdrain%0d rdata", i), 32'(bus0.rdata), 32'(8'h66 + 8'(i)));
        end
        chk("wrapdrain rempty", 32'(bus0.rempty), 32'd1);
        drive0(1'b0, 1'b0, 1'b0, 8'h00);

        // FWFT instance: zero-latency head word.
        tick();
        chk("fw rst count",  32'(bus1.count),  32'd0);
        chk("fw rst rempty", 32'(bus1.rempty), 32'd1);
        drive1(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        chk("fw wr rempty", 32'(bus1.rempty), 32'd0);
        chk("fw wr rdata",  32'(bus1.rdata),  32'hA5);
        drive1(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("fw idle rdata", 32'(bus1.rdata), 32'hA5);
        drive1(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("fw pop rempty", 32'(bus1.rempty), 32'd1);
        chk("fw pop count",  32'(bus1.count),  32'd0);
        for (int i = 0; i < 5; i++) begin
            drive1(1'b0, 1'b1, 1'b0, 8'hB0 + 8'(i));
            tick();
        end
        chk("fw fill count", 32'(bus1.count), 32'd5);
        chk("fw fill rdata", 32'(bus1.rdata), 32'hB0);
        // Reset mid-fill wins over a concurrent write.
        drive1(1'b1, 1'b1, 1'b0, 8'hCC);
        tick();
        chk("fw midrst count",  32'(bus1.count),  32'd0);
        chk("fw midrst rempty", 32'(bus1.rempty), 32'd1);
        drive1(1'b0, 1'b1, 1'b0, 8'hD1);
        tick();
        chk("fw post count", 32'(bus1.count), 32'd1);
        chk("fw post rdata", 32'(bus1.rdata), 32'hD1);
        drive1(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("fw last rempty", 32'(bus1.rempty),    32'd1);
        chk("fw last unf",    32'(bus1.underflow), 32'd0);
        tick();
        chk("fw unf", 32'(bus1.underflow), 32'd1);
        drive1(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
